// File: rtl/tape_audio_out.sv
// tape_audio_out: turns the PIA cassette-out bit into a slew-limited square wave
// with an activity fade in/out, and mixes it into the core audio with saturation.
module tape_audio_out #(
  parameter int unsigned CLK_RATE  = 42954545,
  parameter logic [15:0] AMPLITUDE = 16'h2000,
  parameter logic [15:0] SLEW_STEP = 16'h0100,
  parameter int unsigned SLEW_DIV  = 4,
  parameter int unsigned IDLE_MS   = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tape_bit,
  input  logic [15:0] audio_in,
  output logic [15:0] audio_out,
  output logic        active,
  output logic [15:0] half_period
);
  localparam logic [31:0] IDLE_CYCLES = 32'(CLK_RATE / 1000 * IDLE_MS);
  localparam int DW = SLEW_DIV > 1 ? $clog2(SLEW_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SLEW_DIV - 1);
  localparam logic signed [17:0] AMP = {2'b00, AMPLITUDE};
  localparam logic signed [17:0] STEP = {2'b00, SLEW_STEP};
  localparam logic signed [17:0] SAT_HI = 18'sh07FFF;
  localparam logic signed [17:0] SAT_LO = -18'sh08000;
  typedef enum logic [1:0] {IDLE, RUN, FADE} state_t;
  state_t state_q, state_d;
  logic bit_q, bit_edge, tick, timeout, near;
  logic [31:0] idle_q;
  logic [15:0] cnt_q;
  logic [DW-1:0] div_q;
  logic signed [16:0] level_q, level_d;
  logic signed [17:0] level_x, target, diff, sum;
  always_comb begin
    bit_edge = bit_q ^ tape_bit;
    tick = div_q == DIV_LAST;
    timeout = idle_q == IDLE_CYCLES;
    level_x = {level_q[16], level_q};
    target = state_q != RUN ? '0 : bit_q ? AMP : -AMP;
    diff = target - level_x;
    near = diff <= STEP && diff >= -STEP;
    level_d = state_q == IDLE ? '0 : !tick ? level_q : near ? target[16:0]
            : diff > 0 ? 17'(level_x + STEP) : 17'(level_x - STEP);
    // an edge arriving together with the timeout keeps the tone running
    state_d = (state_q != RUN && bit_edge && enable) ? RUN
            : (state_q == RUN && (!enable || (timeout && !bit_edge))) ? FADE
            : (state_q == FADE && level_q == '0) ? IDLE : state_q;
    sum = {{2{audio_in[15]}}, audio_in} + level_x;
  end
  always_ff @(posedge clk) begin
    bit_q <= tape_bit;
    if (reset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      idle_q      <= IDLE_CYCLES;
      cnt_q       <= '0;
      div_q       <= '0;
      half_period <= '0;
      audio_out   <= '0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      idle_q      <= bit_edge ? '0 : timeout ? idle_q : idle_q + 32'd1;
      cnt_q       <= bit_edge ? 16'd1 : &cnt_q ? cnt_q : cnt_q + 16'd1;
      half_period <= bit_edge ? cnt_q : half_period;
      div_q       <= tick ? '0 : div_q + DW'(1);
      audio_out   <= sum > SAT_HI ? 16'h7FFF : sum < SAT_LO ? 16'h8000 : sum[15:0];
      active      <= state_q != IDLE;
    end
  end
endmodule

// File: tb/tb_tape_audio_out.sv
// tb_tape_audio_out: scenario tasks with randomized stimulus against a behavioural tape-out model.
module tb_tape_audio_out;
  localparam int CLK_RATE = 4000;
  localparam int IDLE_C = CLK_RATE / 1000 * 500;
  localparam int AMP = 'h2000;
  localparam int STEP = 'h100;
  localparam int SDIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_FADE = 2;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, tape_bit = 1'b0;
  logic [15:0] audio_in = '0;
  logic [15:0] audio_out, half_period;
  logic active;
  int passed = 0, total = 0;
  tape_audio_out #(.CLK_RATE(CLK_RATE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tape_bit(tape_bit),
    .audio_in(audio_in), .audio_out(audio_out), .active(active), .half_period(half_period)
  );
  always #5 clk = ~clk;
  // reference model: tone level walks toward its target one step per slew tick
  logic m_prev = 1'b0, m_active = 1'b0, me;
  int m_level = 0, m_mode = M_IDLE, m_quiet = IDLE_C, m_since = 0, m_half = 0, m_div = 0, m_out = 0;
  int m_tgt, m_sum;
  assign me = m_prev != tape_bit;
  assign m_tgt = m_mode == M_RUN ? (m_prev ? AMP : -AMP) : 0;
  assign m_sum = int'($signed(audio_in)) + m_level;
  function automatic int approach(input int l, input int t);
    int up, dn;
    up = l + STEP;
    dn = l - STEP;
    return t > l ? (up < t ? up : t) : (dn > t ? dn : t);
  endfunction
  always @(posedge clk) begin
    m_prev <= tape_bit;
    if (reset) begin
      m_out <= 0; m_active <= 1'b0; m_half <= 0; m_level <= 0; m_mode <= M_IDLE;
      m_quiet <= IDLE_C; m_since <= 0; m_div <= 0;
    end else begin
      m_out <= m_sum > 32767 ? 32767 : m_sum < -32768 ? -32768 : m_sum;
      m_active <= m_mode != M_IDLE;
      m_level <= m_mode == M_IDLE ? 0 : m_div == SDIV - 1 ? approach(m_level, m_tgt) : m_level;
      if (m_mode != M_RUN && me && enable) m_mode <= M_RUN;
      else if (m_mode == M_RUN && (!enable || (!me && m_quiet == IDLE_C))) m_mode <= M_FADE;
      else if (m_mode == M_FADE && m_level == 0) m_mode <= M_IDLE;
      if (me) begin
        m_half <= m_since; m_since <= 1; m_quiet <= 0;
      end else begin
        m_since <= m_since < 65535 ? m_since + 1 : 65535;
        m_quiet <= m_quiet < IDLE_C ? m_quiet + 1 : IDLE_C;
      end
      m_div <= (m_div + 1) % SDIV;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1; audio_in = 16'h0123;
    repeat (3) step();
    total++;
    if ({audio_out, active, half_period} !== 33'h0) $display("FAIL reset_state dut=%h/%b/%h want 0/0/0", audio_out, active, half_period);
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (audio_out !== 16'h0123 || active !== 1'b0) $display("FAIL reset_release dut=%h/%b want 0123/0", audio_out, active);
    else passed++;
  endtask
  task automatic test_ramp();
    int t_first = -1, t_full = -1;
    enable = 1'b1; audio_in = '0; tape_bit = 1'b1;
    for (int i = 0; i < 140; i++) begin
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL ramp cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
      if (t_first < 0 && audio_out === 16'h0100) t_first = i;
      if (t_full < 0 && audio_out === 16'h2000) t_full = i;
    end
    total++;
    if (audio_out !== 16'h2000 || active !== 1'b1) $display("FAIL ramp_final dut=%h/%b want 2000/1", audio_out, active);
    else passed++;
    total++;
    if (t_full - t_first !== 124) $display("FAIL ramp_time got %0d cycles want 124", t_full - t_first);
    else passed++;
  endtask
  task automatic test_period();
    int t_leave = -1, t_arr = -1;
    audio_in = '0;
    for (int n = 0; n < 4; n++) begin
      tape_bit = ~tape_bit;
      for (int i = 0; i < 1000; i++) begin
        step();
        total++;
        if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
          $display("FAIL period cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
        else passed++;
        if (n == 3 && t_leave < 0 && audio_out !== 16'hE000) t_leave = i;
        if (n == 3 && t_arr < 0 && audio_out === 16'h2000) t_arr = i;
      end
    end
    total++;
    if (half_period !== 16'd1000) $display("FAIL half_period dut=%0d want 1000", half_period);
    else passed++;
    total++;
    if (t_arr - t_leave !== 252) $display("FAIL swing_time got %0d cycles want 252", t_arr - t_leave);
    else passed++;
  endtask
  task automatic test_saturate();
    audio_in = 16'h7F00;
    repeat (2) step();
    total++;
    if (audio_out !== 16'h7FFF) $display("FAIL sat_pos dut=%h want 7fff", audio_out);
    else passed++;
    tape_bit = 1'b0; audio_in = '0;
    for (int i = 0; i < 300; i++) begin
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL sat_ramp cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
    audio_in = 16'h8100;
    repeat (2) step();
    total++;
    if (audio_out !== 16'h8000) $display("FAIL sat_neg dut=%h want 8000", audio_out);
    else passed++;
  endtask
  task automatic test_fade();
    int prev, d;
    audio_in = 16'h0040;
    for (int i = 0; i < IDLE_C + 200; i++) begin
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL fade cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
    total++;
    if (active !== 1'b0 || audio_out !== 16'h0040) $display("FAIL fade_idle dut=%h/%b want 0040/0", audio_out, active);
    else passed++;
    tape_bit = 1'b1;
    for (int i = 0; i < IDLE_C + 40; i++) begin
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL refade cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
    total++;
    if (!(active === 1'b1 && $signed(audio_out) < 16'sh2040 && $signed(audio_out) > 16'sh0040))
      $display("FAIL fade_started dut=%h/%b want 0040<out<2040 and active", audio_out, active);
    else passed++;
    prev = int'($signed(audio_out));
    tape_bit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      d = int'($signed(audio_out)) - prev;
      prev = int'($signed(audio_out));
      total++;
      if (d > STEP || d < -STEP || active !== 1'b1) $display("FAIL resume_jump cyc=%0d delta=%0d active=%b want |delta|<=256 active=1", i, d, active);
      else passed++;
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL resume cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    bit found = 1'b0;
    reset = 1'b1; step(); reset = 1'b0; step();
    audio_in = '0; tape_bit = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = audio_out === 16'h0A00;
    end
    total++;
    if (!found) $display("FAIL midramp_timeout dut=%h want 0a00 within 200 cycles", audio_out);
    else passed++;
    reset = 1'b1;
    step();
    total++;
    if (audio_out !== 16'h0 || active !== 1'b0) $display("FAIL midramp_reset dut=%h/%b want 0000/0", audio_out, active);
    else passed++;
    reset = 1'b0; audio_in = 16'h0123;
    step();
    total++;
    if (audio_out !== 16'h0123 || active !== 1'b0) $display("FAIL midramp_release dut=%h/%b want 0123/0", audio_out, active);
    else passed++;
  endtask
  task automatic test_disable();
    enable = 1'b1; tape_bit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 200) enable = 1'b0;
      if (i > 200 && i % 20 == 0) tape_bit = ~tape_bit;
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL disable cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
    total++;
    if (active !== 1'b0 || audio_out !== 16'h0123) $display("FAIL disable_idle dut=%h/%b want 0123/0", audio_out, active);
    else passed++;
  endtask
  task automatic test_back_to_back();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) tape_bit = ~tape_bit;
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      audio_in = 16'($urandom);
      step();
      total++;
      if ({audio_out, active, half_period} !== {16'(m_out), m_active, 16'(m_half)})
        $display("FAIL random cyc=%0d dut=%h/%b/%h want %h/%b/%h", i, audio_out, active, half_period, 16'(m_out), m_active, 16'(m_half));
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_period();
    test_saturate();
    test_fade();
    test_reset_mid();
    test_disable();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
